// File: rtl/int_div_seq.sv
// Sequential radix-2 restoring unsigned divider: one quotient bit per clock,
// valid/ready handshakes on the operand and result sides.
module int_div_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;
    logic             dz;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Trial subtract is WIDTH+1 wide so the borrow survives; a restored value
    // is always below the divisor, so its top bit is zero and drops safely.
    assign shifted = {r, q[WIDTH-1]};
    assign trial   = shifted - {1'b0, d};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
            q     <= '0;
            r     <= '0;
            d     <= '0;
            cnt   <= '0;
            dz    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid) begin
                        d     <= Divisor;
                        cnt   <= CW'(WIDTH - 1);
                        state <= BUSY;
                        // Zero divisor spends one BUSY cycle with the result
                        // already loaded, giving a one-edge accept-to-valid delay.
                        if (Divisor == '0) begin
                            q  <= '1;
                            r  <= Dividend;
                            dz <= 1'b1;
                        end else begin
                            q  <= Dividend;
                            r  <= '0;
                            dz <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (dz) begin
                        state <= DONE;
                    end else begin
                        if (!trial[WIDTH]) begin
                            r <= trial[WIDTH-1:0];
                            q <= {q[WIDTH-2:0], 1'b1};
                        end else begin
                            r <= shifted[WIDTH-1:0];
                            q <= {q[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt - CW'(1);
                        if (cnt == '0) begin
                            dz    <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (OutReady) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign InReady   = (state == IDLE) && !Rst;
    assign OutValid  = (state == DONE);
    assign Quotient  = q;
    assign Remainder = r;
    assign DivByZero = dz;

endmodule
